// File: rtl/rv32_regfile_mp_pkg.sv
// Shared definitions for the rv32 integer register file family.
package rv32_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Address width for a given register count; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rv32_regfile_mp_if.sv
// Read, writeback and issue signals of the multi-port register file.
interface rv32_regfile_mp_if
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NR_READ  = 2,
    parameter int unsigned NR_WRITE = 1
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [NR_READ*AW-1:0]    rs_addr;
    logic [NR_READ*XLEN-1:0]  rs_value_o;
    logic [NR_READ-1:0]       rs_busy_o;
    logic [NR_WRITE-1:0]      wr_en;
    logic [NR_WRITE*AW-1:0]   wr_addr;
    logic [NR_WRITE*XLEN-1:0] wr_value;
    logic                     issue_en;
    logic [AW-1:0]            issue_addr;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_value, issue_en, issue_addr,
        input  rs_value_o, rs_busy_o
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_value, issue_en, issue_addr,
        output rs_value_o, rs_busy_o
    );

endinterface

// File: rtl/rv32_regfile_wrsel.sv
// Selects the write port targeting a given address; highest port index wins.
module rv32_regfile_wrsel
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned AW       = REG_ADDR_W,
    parameter int unsigned NR_WRITE = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [AW-1:0]            addr,
    input  logic [NR_WRITE-1:0]      wr_en,
    input  logic [NR_WRITE*AW-1:0]   wr_addr,
    input  logic [NR_WRITE*XLEN-1:0] wr_value,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned p = 0; p < NR_WRITE; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wr_value[p*XLEN +: XLEN];
            end
        end
        // A hardwired zero register never sees a write, so it never hits.
        if ((ZERO_REG != 0) && (addr == AW'(REG_ZERO))) begin
            hit  = 1'b0;
            data = '0;
        end
    end

endmodule

// File: rtl/rv32_regfile_mp.sv
// Parametrised multi-port integer register file with optional write bypass
// and a per-register busy scoreboard for pending writebacks.
module rv32_regfile_mp
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NR_READ  = 2,
    parameter int unsigned NR_WRITE = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input logic              clk,
    input logic              reset,
    rv32_regfile_mp_if.slave bus
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [XLEN-1:0]  regs      [DEPTH];
    logic [XLEN-1:0]  reg_wdata [DEPTH];
    logic [DEPTH-1:0] reg_hit;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             issue_ok;

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        rv32_regfile_wrsel #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NR_WRITE (NR_WRITE),
            .ZERO_REG (ZERO_REG)
        ) u_sel (
            .addr     (AW'(r)),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_value (bus.wr_value),
            .hit      (reg_hit[r]),
            .data     (reg_wdata[r])
        );
    end

    assign issue_ok = bus.issue_en
                   && (32'(bus.issue_addr) < DEPTH)
                   && !((ZERO_REG != 0) && (bus.issue_addr == AW'(REG_ZERO)));

    // Clear from writeback first, then set from issue, so a same-cycle issue wins.
    always_comb begin
        busy_next = busy & ~reg_hit;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (issue_ok && (bus.issue_addr == AW'(r))) busy_next[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (reg_hit[r]) regs[r] <= reg_wdata[r];
            end
            busy <= busy_next;
        end
    end

    for (genvar k = 0; k < NR_READ; k++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic [XLEN-1:0] rd_value;
        logic            rd_busy;

        assign rd_addr = bus.rs_addr[k*AW +: AW];

        if (BYPASS != 0) begin : g_byp
            rv32_regfile_wrsel #(
                .XLEN     (XLEN),
                .AW       (AW),
                .NR_WRITE (NR_WRITE),
                .ZERO_REG (ZERO_REG)
            ) u_byp (
                .addr     (rd_addr),
                .wr_en    (bus.wr_en),
                .wr_addr  (bus.wr_addr),
                .wr_value (bus.wr_value),
                .hit      (byp_hit),
                .data     (byp_data)
            );
        end else begin : g_nobyp
            assign byp_hit  = 1'b0;
            assign byp_data = '0;
        end

        // Addresses beyond DEPTH match no entry and read as zero, not busy.
        always_comb begin
            rd_value = '0;
            rd_busy  = 1'b0;
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (rd_addr == AW'(r)) begin
                    rd_value = regs[r];
                    rd_busy  = busy[r];
                end
            end
            if (byp_hit && (32'(rd_addr) < DEPTH)) begin
                rd_value = byp_data;
                rd_busy  = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr == AW'(REG_ZERO))) begin
                rd_value = '0;
                rd_busy  = 1'b0;
            end
        end

        assign bus.rs_value_o[k*XLEN +: XLEN] = rd_value;
        assign bus.rs_busy_o[k]               = rd_busy;
    end

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// Directed bench for rv32_regfile_mp: a bypassed dual-write instance and a
// non-bypassed single-write instance with DEPTH=24, checked against a bench model.
module tb_rv32_regfile_mp;

    logic clk;
    logic reset;

    logic [4:0]  rs  [2];
    logic [1:0]  wen;
    logic [4:0]  wa  [2];
    logic [31:0] wv  [2];
    logic        ien;
    logic [4:0]  ia;

    int n_checks = 0;
    int n_fail   = 0;

    rv32_regfile_mp_if #(.XLEN(32), .DEPTH(32), .NR_READ(2), .NR_WRITE(2)) bus_a ();
    rv32_regfile_mp_if #(.XLEN(32), .DEPTH(24), .NR_READ(2), .NR_WRITE(1)) bus_b ();

    rv32_regfile_mp #(
        .XLEN(32), .DEPTH(32), .NR_READ(2), .NR_WRITE(2), .BYPASS(1), .ZERO_REG(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    rv32_regfile_mp #(
        .XLEN(32), .DEPTH(24), .NR_READ(2), .NR_WRITE(1), .BYPASS(0), .ZERO_REG(1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_a.rs_addr    = {rs[1], rs[0]};
    assign bus_a.wr_en      = wen;
    assign bus_a.wr_addr    = {wa[1], wa[0]};
    assign bus_a.wr_value   = {wv[1], wv[0]};
    assign bus_a.issue_en   = ien;
    assign bus_a.issue_addr = ia;

    assign bus_b.rs_addr    = {rs[1], rs[0]};
    assign bus_b.wr_en      = wen[0];
    assign bus_b.wr_addr    = wa[0];
    assign bus_b.wr_value   = wv[0];
    assign bus_b.issue_en   = ien;
    assign bus_b.issue_addr = ia;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Bench model: config 0 = dut_a, config 1 = dut_b.
    int unsigned cfg_depth [2] = '{32, 24};
    int          cfg_nw    [2] = '{2, 1};
    bit          cfg_byp   [2] = '{1'b1, 1'b0};

    logic [31:0] mem [2][32];
    bit          bsy [2][32];
    bit          model_ok = 1'b0;

    function automatic bit write_hits(input int c, input logic [4:0] a);
        for (int p = 0; p < cfg_nw[c]; p++)
            if (wen[p] && wa[p] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_val(input int c, input logic [4:0] a);
        if (32'(a) >= cfg_depth[c] || a == 5'd0) return 32'd0;
        if (cfg_byp[c])
            for (int p = cfg_nw[c] - 1; p >= 0; p--)
                if (wen[p] && wa[p] == a) return wv[p];
        return mem[c][a];
    endfunction

    function automatic bit model_busy(input int c, input logic [4:0] a);
        if (32'(a) >= cfg_depth[c] || a == 5'd0) return 1'b0;
        if (cfg_byp[c] && write_hits(c, a)) return 1'b0;
        return bsy[c][a];
    endfunction

    function automatic logic [31:0] dut_val(input int c, input int k);
        logic [63:0] v;
        v = (c == 0) ? bus_a.rs_value_o : bus_b.rs_value_o;
        return v[k*32 +: 32];
    endfunction

    function automatic logic dut_busy(input int c, input int k);
        logic [1:0] b;
        b = (c == 0) ? bus_a.rs_busy_o : bus_b.rs_busy_o;
        return b[k];
    endfunction

    // Compare mid-cycle, then advance the model as the coming posedge will.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("cfg%0d_val%0d_x%0d", c, k, rs[k]),
                          64'(dut_val(c, k)), 64'(model_val(c, rs[k])));
                    check($sformatf("cfg%0d_busy%0d_x%0d", c, k, rs[k]),
                          64'(dut_busy(c, k)), 64'(model_busy(c, rs[k])));
                end
            end
        end
        if (reset) begin
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 32; r++) begin
                    mem[c][r] = 32'd0;
                    bsy[c][r] = 1'b0;
                end
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < cfg_nw[c]; p++) begin
                    if (wen[p] && 32'(wa[p]) < cfg_depth[c] && wa[p] != 5'd0) begin
                        mem[c][wa[p]] = wv[p];
                        bsy[c][wa[p]] = 1'b0;
                    end
                end
                if (ien && 32'(ia) < cfg_depth[c] && ia != 5'd0) bsy[c][ia] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 2'b00;
        ien = 1'b0;
        ia  = 5'd0;
        wa[0] = 5'd0; wa[1] = 5'd0;
        wv[0] = 32'd0; wv[1] = 32'd0;
    endtask

    task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
        rs[0] = a0;
        rs[1] = a1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        set_rs(5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;

        // Sweep every address after reset.
        for (int a = 0; a < 32; a++) begin
            tick();
            set_rs(5'(a), 5'(31 - a));
            #1;
            check("rst_val_a", bus_a.rs_value_o, 64'd0);
            check("rst_busy_a", 64'(bus_a.rs_busy_o), 64'd0);
        end

        // Write x4 = 546: bypassed on A this cycle, B only next cycle.
        tick(); idle();
        wen = 2'b01; wa[0] = 5'd4; wv[0] = 32'd546;
        set_rs(5'd4, 5'd4);
        #1;
        check("byp_a", bus_a.rs_value_o, {32'd546, 32'd546});
        check("nobyp_b_now", bus_b.rs_value_o, 64'd0);
        tick(); idle();
        #1;
        check("nobyp_b_next", bus_b.rs_value_o, {32'd546, 32'd546});

        // x0 protection, including issue of x0.
        tick(); idle();
        wen = 2'b01; wa[0] = 5'd0; wv[0] = 32'd654;
        ien = 1'b1; ia = 5'd0;
        set_rs(5'd0, 5'd0);
        #1;
        check("x0_byp_a", bus_a.rs_value_o, 64'd0);
        tick(); idle();
        #1;
        check("x0_val_b", bus_b.rs_value_o, 64'd0);
        check("x0_busy_a", 64'(bus_a.rs_busy_o), 64'd0);

        // Two ports write x7 in the same cycle; port 1 wins.
        tick(); idle();
        wen = 2'b11; wa[0] = 5'd7; wv[0] = 32'd11; wa[1] = 5'd7; wv[1] = 32'd22;
        set_rs(5'd7, 5'd7);
        #1;
        check("conflict_byp_a", bus_a.rs_value_o, {32'd22, 32'd22});
        tick(); idle();
        #1;
        check("conflict_next_a", bus_a.rs_value_o, {32'd22, 32'd22});
        check("conflict_next_b", bus_b.rs_value_o, {32'd11, 32'd11});

        // Scoreboard: issue x5, then write it back.
        tick(); idle();
        ien = 1'b1; ia = 5'd5;
        set_rs(5'd5, 5'd5);
        #1;
        check("issue_same_cycle_a", 64'(bus_a.rs_busy_o), 64'd0);
        tick(); idle();
        #1;
        check("busy_after_issue_a", 64'(bus_a.rs_busy_o), 64'd3);
        check("busy_after_issue_b", 64'(bus_b.rs_busy_o), 64'd3);
        tick(); idle();
        wen = 2'b01; wa[0] = 5'd5; wv[0] = 32'd99;
        #1;
        check("wb_mask_a", 64'(bus_a.rs_busy_o), 64'd0);
        check("wb_nomask_b", 64'(bus_b.rs_busy_o), 64'd3);
        tick(); idle();
        #1;
        check("wb_cleared_b", 64'(bus_b.rs_busy_o), 64'd0);
        check("wb_val_b", bus_b.rs_value_o, {32'd99, 32'd99});

        // Issue and writeback of x5 together: set wins.
        tick(); idle();
        ien = 1'b1; ia = 5'd5;
        wen = 2'b01; wa[0] = 5'd5; wv[0] = 32'd5;
        tick(); idle();
        #1;
        check("set_wins_a", 64'(bus_a.rs_busy_o), 64'd3);
        check("set_wins_b", 64'(bus_b.rs_busy_o), 64'd3);

        // x26 is out of range for B (DEPTH=24) but valid for A.
        tick(); idle();
        wen = 2'b01; wa[0] = 5'd26; wv[0] = 32'h1234;
        ien = 1'b1; ia = 5'd26;
        set_rs(5'd26, 5'd4);
        tick(); idle();
        #1;
        check("oor_val_b", bus_b.rs_value_o, {32'd546, 32'd0});
        check("oor_busy_b", 64'(bus_b.rs_busy_o), 64'd0);
        check("inrange_val_a", bus_a.rs_value_o, {32'd546, 32'h1234});
        check("inrange_busy_a", 64'(bus_a.rs_busy_o), 64'd1);

        // Reset mid-stream together with a write of x6.
        tick(); idle();
        reset = 1'b1;
        wen = 2'b01; wa[0] = 5'd6; wv[0] = 32'd77;
        set_rs(5'd6, 5'd4);
        #1;
        check("rst_cycle_byp_a", bus_a.rs_value_o, {32'd546, 32'd77});
        tick(); idle();
        reset = 1'b0;
        #1;
        check("post_rst_val_a", bus_a.rs_value_o, 64'd0);
        check("post_rst_val_b", bus_b.rs_value_o, 64'd0);
        tick();
        set_rs(5'd5, 5'd26);
        #1;
        check("post_rst_busy_a", 64'(bus_a.rs_busy_o), 64'd0);
        check("post_rst_busy_b", 64'(bus_b.rs_busy_o), 64'd0);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
